regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 8x8 register file between two writeback requesters: REQ0 (ALU result) and REQ1 (data-memory load).
- Uses a valid/ready handshake with round-robin arbitration. Drives the register file write enable, address and data from registered outputs.
- Also sequences a bulk clear, which writes zero to every register over consecutive cycles.
- Sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_write_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the single register-file write port between REQ0 (ALU) and
//          REQ1 (load) with round-robin valid/ready arbitration, and sequences
//          a bulk clear that writes zero to every register on consecutive cycles.
// Latency: an accepted request appears on WR_EN/WR_ADDR/WR_DATA one cycle later.
// Backpressure: READYs drop while a clear is requested or running; only one
//          requester is granted per cycle.
// Ports:
//   CLK, RESET                     clock and synchronous active-high reset
//   REQn_VALID/READY/ADDR/DATA     requester n handshake and write payload
//   CLEAR_REQ, CLEAR_BUSY          bulk clear request (level) and progress flag
//   WR_EN, WR_ADDR, WR_DATA        registered register-file write port
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_DATA,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_DATA,
  input  logic                  CLEAR_REQ,
  output logic                  CLEAR_BUSY,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [DATA_WIDTH-1:0] WR_DATA
);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  last_grant;   // index of the most recently granted requester
  logic                  accept;
  logic                  grant0;
  logic                  grant1;

  // A pending or running clear blocks both requesters. Under contention the
  // requester that was not granted last time wins.
  always_comb begin
    accept = (state == RUN) && !CLEAR_REQ;
    grant0 = accept && REQ0_VALID && (!REQ1_VALID || last_grant);
    grant1 = accept && REQ1_VALID && (!REQ0_VALID || !last_grant);
  end

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;
  assign CLEAR_BUSY = (state == CLEAR);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= RUN;
      cnt        <= '0;
      last_grant <= 1'b1;
      WR_EN      <= 1'b0;
      WR_ADDR    <= '0;
      WR_DATA    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (CLEAR_REQ) begin
            // Entry cycle of a clear issues no write.
            state <= CLEAR;
            cnt   <= '0;
            WR_EN <= 1'b0;
          end else if (grant0) begin
            WR_EN      <= 1'b1;
            WR_ADDR    <= REQ0_ADDR;
            WR_DATA    <= REQ0_DATA;
            last_grant <= 1'b0;
          end else if (grant1) begin
            WR_EN      <= 1'b1;
            WR_ADDR    <= REQ1_ADDR;
            WR_DATA    <= REQ1_DATA;
            last_grant <= 1'b1;
          end else begin
            // Address and data hold; only the enable drops.
            WR_EN <= 1'b0;
          end
        end
        CLEAR: begin
          WR_EN   <= 1'b1;
          WR_ADDR <= cnt;
          WR_DATA <= '0;
          cnt     <= cnt + 1'b1;   // wraps to zero after the last register
          if (cnt == LAST_ADDR) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          WR_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ0_VALID, REQ0_READY;
  logic [2:0] REQ0_ADDR;
  logic [7:0] REQ0_DATA;
  logic       REQ1_VALID, REQ1_READY;
  logic [2:0] REQ1_ADDR;
  logic [7:0] REQ1_DATA;
  logic       CLEAR_REQ, CLEAR_BUSY;
  logic       WR_EN;
  logic [2:0] WR_ADDR;
  logic [7:0] WR_DATA;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
    .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
    .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA),
    .CLEAR_REQ(CLEAR_REQ), .CLEAR_BUSY(CLEAR_BUSY),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       rst, clr;
    logic       v0; logic [2:0] a0; logic [7:0] d0;
    logic       v1; logic [2:0] a1; logic [7:0] d1;
    logic       er0, er1;                       // READYs during the cycle
    logic       een; logic [2:0] eaddr; logic [7:0] edata; logic ebusy; // after the edge
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rst, input logic clr,
                       input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [7:0] d1);
    RESET = rst; CLEAR_REQ = clr;
    REQ0_VALID = v0; REQ0_ADDR = a0; REQ0_DATA = d0;
    REQ1_VALID = v1; REQ1_ADDR = a1; REQ1_DATA = d1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [2:0] a,
                        input logic [7:0] d, input logic busy);
    chk({tag, ".wr_en"}, 32'(WR_EN), 32'(en));
    chk({tag, ".wr_addr"}, 32'(WR_ADDR), 32'(a));
    chk({tag, ".wr_data"}, 32'(WR_DATA), 32'(d));
    chk({tag, ".busy"}, 32'(CLEAR_BUSY), 32'(busy));
  endtask

  function automatic vec_t mk(logic rst, logic clr,
                              logic v0, logic [2:0] a0, logic [7:0] d0,
                              logic v1, logic [2:0] a1, logic [7:0] d1,
                              logic er0, logic er1,
                              logic een, logic [2:0] eaddr, logic [7:0] edata, logic ebusy);
    vec_t v;
    v.rst = rst; v.clr = clr;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.er0 = er0; v.er1 = er1;
    v.een = een; v.eaddr = eaddr; v.edata = edata; v.ebusy = ebusy;
    return v;
  endfunction

  // Behavioural reference: a count of clear writes still owed plus the
  // round-robin preference, expressed directly from the arbitration rules.
  int         m_clear_left;
  int         m_last;
  logic       m_en;
  logic [2:0] m_addr;
  logic [7:0] m_data;

  initial begin
    vec_t vecs[10];
    string tag;
    logic e0, e1;
    logic rr, rc, rv0, rv1;
    logic [2:0] ra0, ra1;
    logic [7:0] rd0, rd1;
    logic pend0, pend1;
    int clr_hold;

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("reset.rdy0", 32'(REQ0_READY), 0);
    chk("reset.rdy1", 32'(REQ1_READY), 0);
    chk_wr("reset", 0, 0, 0, 0);

    // Single write, alternation after reset, and a same-address pair.
    vecs[0] = mk(0,0, 1,3,8'h5A, 0,0,0,     1,0, 1,3,8'h5A,0);
    vecs[1] = mk(0,0, 0,0,0,     0,0,0,     0,0, 0,3,8'h5A,0);
    vecs[2] = mk(1,0, 0,0,0,     0,0,0,     0,0, 0,0,8'h00,0);
    vecs[3] = mk(0,0, 1,1,8'h11, 1,2,8'h22, 1,0, 1,1,8'h11,0);
    vecs[4] = mk(0,0, 1,1,8'h11, 1,2,8'h22, 0,1, 1,2,8'h22,0);
    vecs[5] = mk(0,0, 1,1,8'h11, 1,2,8'h22, 1,0, 1,1,8'h11,0);
    vecs[6] = mk(0,0, 1,1,8'h11, 1,2,8'h22, 0,1, 1,2,8'h22,0);
    vecs[7] = mk(0,0, 0,0,0,     1,5,8'hAA, 0,1, 1,5,8'hAA,0);
    vecs[8] = mk(0,0, 1,5,8'hBB, 0,0,0,     1,0, 1,5,8'hBB,0);
    vecs[9] = mk(0,0, 0,0,0,     0,0,0,     0,0, 0,5,8'hBB,0);
    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].rst, vecs[i].clr, vecs[i].v0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].a1, vecs[i].d1);
      #2;
      chk({tag, ".rdy0"}, 32'(REQ0_READY), 32'(vecs[i].er0));
      chk({tag, ".rdy1"}, 32'(REQ1_READY), 32'(vecs[i].er1));
      tick();
      chk_wr(tag, vecs[i].een, vecs[i].eaddr, vecs[i].edata, vecs[i].ebusy);
    end

    // One-cycle clear request while REQ1 waits: nine blocked cycles, then grant.
    drive(0, 1, 0, 0, 0, 1, 6, 8'h66);
    #2;
    chk("clr1.rdy1_req", 32'(REQ1_READY), 0);
    tick();
    chk_wr("clr1.entry", 0, 5, 8'hBB, 1);
    CLEAR_REQ = 0;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk($sformatf("clr1.rdy1_%0d", i), 32'(REQ1_READY), 0);
      tick();
      chk_wr($sformatf("clr1.w%0d", i), 1, 3'(i), 0, i < 7);
    end
    #2;
    chk("clr1.rdy1_after", 32'(REQ1_READY), 1);
    tick();
    chk_wr("clr1.req1", 1, 6, 8'h66, 0);
    REQ1_VALID = 0;

    // Continuous clear request: back-to-back clears with one idle cycle each.
    drive(0, 1, 1, 1, 8'h11, 0, 0, 0);
    for (int rep = 0; rep < 2; rep++) begin
      #2;
      chk($sformatf("clrh%0d.rdy0_req", rep), 32'(REQ0_READY), 0);
      tick();
      chk($sformatf("clrh%0d.idle_en", rep), 32'(WR_EN), 0);
      chk($sformatf("clrh%0d.busy", rep), 32'(CLEAR_BUSY), 1);
      for (int i = 0; i < 8; i++) begin
        #2;
        chk($sformatf("clrh%0d.rdy0_%0d", rep, i), 32'(REQ0_READY), 0);
        tick();
        chk_wr($sformatf("clrh%0d.w%0d", rep, i), 1, 3'(i), 0, i < 7);
      end
    end
    CLEAR_REQ = 0;
    #2;
    chk("clrh.rdy0_after", 32'(REQ0_READY), 1);
    tick();
    chk_wr("clrh.req0", 1, 1, 8'h11, 0);
    REQ0_VALID = 0;

    // Reset in the middle of a clear, then contention favours REQ0.
    CLEAR_REQ = 1;
    tick();
    CLEAR_REQ = 0;
    for (int i = 0; i < 4; i++) tick();
    chk_wr("rstclr.pre", 1, 3, 0, 1);
    RESET = 1;
    tick();
    chk_wr("rstclr.post", 0, 0, 0, 0);
    drive(0, 0, 1, 2, 8'h22, 1, 3, 8'h33);
    #2;
    chk("rstclr.rdy0", 32'(REQ0_READY), 1);
    chk("rstclr.rdy1", 32'(REQ1_READY), 0);
    tick();
    chk_wr("rstclr.w0", 1, 2, 8'h22, 0);
    REQ0_VALID = 0;
    #2;
    chk("rstclr.rdy1b", 32'(REQ1_READY), 1);
    tick();
    chk_wr("rstclr.w1", 1, 3, 8'h33, 0);
    REQ1_VALID = 0;

    // Randomized traffic against the reference model.
    pend0 = 0; pend1 = 0; clr_hold = 0;
    ra0 = 0; ra1 = 0; rd0 = 0; rd1 = 0;
    m_clear_left = 0; m_last = 1; m_en = 0; m_addr = 0; m_data = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rr = (cyc == 0) || ($urandom_range(0, 199) == 0);
      if (clr_hold > 0) clr_hold--;
      else if ($urandom_range(0, 39) == 0) clr_hold = $urandom_range(1, 12);
      rc = !rr && (clr_hold > 0);
      if (rr) begin pend0 = 0; pend1 = 0; end
      else begin
        if (!pend0 && $urandom_range(0, 2) != 0) begin
          pend0 = 1; ra0 = 3'($urandom); rd0 = 8'($urandom);
        end
        if (!pend1 && $urandom_range(0, 2) != 0) begin
          pend1 = 1; ra1 = 3'($urandom); rd1 = 8'($urandom);
        end
      end
      rv0 = pend0; rv1 = pend1;
      drive(rr, rc, rv0, ra0, rd0, rv1, ra1, rd1);

      e0 = 0; e1 = 0;
      if (m_clear_left == 0 && !rc) begin
        if (rv0 && rv1) begin
          if (m_last == 1) e0 = 1; else e1 = 1;
        end else if (rv0) e0 = 1;
        else if (rv1) e1 = 1;
      end
      #2;
      chk("rnd.rdy0", 32'(REQ0_READY), 32'(e0));
      chk("rnd.rdy1", 32'(REQ1_READY), 32'(e1));

      if (rr) begin
        m_clear_left = 0; m_last = 1; m_en = 0; m_addr = 0; m_data = 0;
      end else if (m_clear_left > 0) begin
        m_en = 1; m_addr = 3'(8 - m_clear_left); m_data = 0; m_clear_left--;
      end else if (rc) begin
        m_clear_left = 8; m_en = 0;
      end else if (e0) begin
        m_en = 1; m_addr = ra0; m_data = rd0; m_last = 0;
      end else if (e1) begin
        m_en = 1; m_addr = ra1; m_data = rd1; m_last = 1;
      end else begin
        m_en = 0;
      end
      if (e0) pend0 = 0;
      if (e1) pend1 = 0;

      tick();
      chk_wr("rnd", m_en, m_addr, m_data, m_clear_left > 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
